pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 13 +
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_target_sel.sv | 52 +++++
 rtl/pc_gen.sv | 99 +++++++++
 tb/tb_pc_gen.sv | 135 +++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: FSM encoding and default reset vector.
package pc_gen_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_if.sv
// Fetch-address interface: redirect/branch requests toward the PC generator, fetch address back out.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);

  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            flush_pc;
  logic [XLEN-1:0] new_pc;
  logic            br_inst;
  logic            br_cond;
  logic            jal_inst;
  logic [XLEN-1:0] br_offset;
  logic            pc_ready;
  logic            pc_valid;
  logic [XLEN-1:0] pc;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  // PC generator side
  modport master (
    input  trap_valid, trap_pc, flush_pc, new_pc,
    input  br_inst, br_cond, jal_inst, br_offset, pc_ready,
    output pc_valid, pc, misalign_err, misalign_addr
  );

  // Pipeline / consumer side
  modport slave (
    output trap_valid, trap_pc, flush_pc, new_pc,
    output br_inst, br_cond, jal_inst, br_offset, pc_ready,
    input  pc_valid, pc, misalign_err, misalign_addr
  );

endinterface : pc_gen_if

// File: rtl/pc_target_sel.sv
// Combinational redirect selection: priority, target arithmetic and alignment check.
module pc_target_sel #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic            halt,
  input  logic            fire,
  input  logic [XLEN-1:0] pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            flush_pc,
  input  logic [XLEN-1:0] new_pc,
  input  logic            br_inst,
  input  logic            br_cond,
  input  logic            jal_inst,
  input  logic [XLEN-1:0] br_offset,
  output logic            trap_c,
  output logic            redir_c,
  output logic            misalign_c,
  output logic [XLEN-1:0] target_c
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

  logic            taken;
  logic [XLEN-1:0] br_target;

  assign taken     = fire & ((br_inst & br_cond) | jal_inst);
  assign br_target = pc + br_offset;

  // Trap beats flush beats taken branch; misaligned flush/branch targets are flagged, not loaded
  always_comb begin
    trap_c     = 1'b0;
    redir_c    = 1'b0;
    misalign_c = 1'b0;
    target_c   = '0;
    if (trap_valid) begin
      trap_c   = 1'b1;
      redir_c  = 1'b1;
      target_c = trap_pc & ~LOW_MASK;
    end else if (flush_pc && !halt) begin
      target_c = new_pc;
      if ((new_pc & LOW_MASK) != '0) misalign_c = 1'b1;
      else                           redir_c    = 1'b1;
    end else if (taken) begin
      target_c = br_target;
      if ((br_target & LOW_MASK) != '0) misalign_c = 1'b1;
      else                              redir_c    = 1'b1;
    end
  end

endmodule : pc_target_sel

// File: rtl/pc_gen.sv
// Program-counter generator: BUBBLE/RUN/HALT fetch FSM with redirect and misalignment reporting.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            fire;
  logic            trap;
  logic            redir;
  logic            misalign;
  logic [XLEN-1:0] target;

  assign fire = pc_valid_q & bus.pc_ready;

  pc_target_sel #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_sel (
    .halt       (state_q == ST_HALT),
    .fire       (fire),
    .pc         (pc_q),
    .trap_valid (bus.trap_valid),
    .trap_pc    (bus.trap_pc),
    .flush_pc   (bus.flush_pc),
    .new_pc     (bus.new_pc),
    .br_inst    (bus.br_inst),
    .br_cond    (bus.br_cond),
    .jal_inst   (bus.jal_inst),
    .br_offset  (bus.br_offset),
    .trap_c     (trap),
    .redir_c    (redir),
    .misalign_c (misalign),
    .target_c   (target)
  );

  // Next-state and next-pc decision
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (redir) begin
      pc_d    = target;
      state_d = ST_RUN;
    end else if (misalign) begin
      misalign_err_d  = 1'b1;
      misalign_addr_d = target;
      state_d         = ST_HALT;
    end else begin
      if (fire) pc_d = pc_q + XLEN'(INC);
      unique case (state_q)
        ST_BUBBLE: state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_BUBBLE;
      endcase
    end
    // trap always exits to RUN; redir already covers it, kept explicit for clarity
    if (trap) state_d = ST_RUN;
    pc_valid_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_BUBBLE;
      pc_q            <= RESET_PC;
      pc_valid_q      <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.misalign_err  = misalign_err_q;
  assign bus.misalign_addr = misalign_addr_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, stall, branch/jal, priority, misalignment, wrap and reset-in-HALT.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc_e, input logic v_e,
                              input logic err_e, input logic [31:0] addr_e);
    check({tag, "_pc"},    bus.pc, pc_e);
    check({tag, "_valid"}, 32'(bus.pc_valid), 32'(v_e));
    check({tag, "_err"},   32'(bus.misalign_err), 32'(err_e));
    check({tag, "_addr"},  bus.misalign_addr, addr_e);
  endtask

  task automatic clear_req();
    bus.trap_valid = 1'b0; bus.trap_pc  = '0;
    bus.flush_pc   = 1'b0; bus.new_pc   = '0;
    bus.br_inst    = 1'b0; bus.br_cond  = 1'b0;
    bus.jal_inst   = 1'b0; bus.br_offset = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_req();
    bus.pc_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    expect_state("reset", 32'h0, 1'b0, 1'b0, 32'h0);

    // release reset: BUBBLE, then RUN with sequential fetch
    rst = 1'b0;
    expect_state("bubble", 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); expect_state("run0", 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); expect_state("run4", 32'h4, 1'b1, 1'b0, 32'h0);
    tick(); expect_state("run8", 32'h8, 1'b1, 1'b0, 32'h0);
    tick(); check("runC", bus.pc, 32'hC);
    tick(); check("run10", bus.pc, 32'h10);

    // stall with a taken branch presented: both ignored
    bus.pc_ready = 1'b0;
    bus.br_inst = 1'b1; bus.br_cond = 1'b1; bus.br_offset = 32'h100;
    tick(); expect_state("stall1", 32'h10, 1'b1, 1'b0, 32'h0);
    tick(); check("stall2", bus.pc, 32'h10);
    bus.jal_inst = 1'b1;
    tick(); check("stall3", bus.pc, 32'h10);
    clear_req();
    bus.pc_ready = 1'b1;

    // aligned flush to 0x100, then backward branch
    bus.flush_pc = 1'b1; bus.new_pc = 32'h100;
    tick(); expect_state("flush", 32'h100, 1'b1, 1'b0, 32'h0);
    clear_req();
    bus.br_inst = 1'b1; bus.br_cond = 1'b1; bus.br_offset = 32'hFFFF_FFF0;
    tick(); expect_state("branch", 32'hF0, 1'b1, 1'b0, 32'h0);
    clear_req();
    bus.jal_inst = 1'b1; bus.br_offset = 32'h20;
    tick(); check("jal", bus.pc, 32'h110);
    clear_req();
    bus.br_inst = 1'b1; bus.br_cond = 1'b0; bus.br_offset = 32'h40;
    tick(); check("not_taken", bus.pc, 32'h114);
    clear_req();

    // trap + flush + jal together: trap wins, low bits cleared, no error
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h803;
    bus.flush_pc = 1'b1; bus.new_pc = 32'h200;
    bus.jal_inst = 1'b1; bus.br_offset = 32'h8;
    tick(); expect_state("prio", 32'h800, 1'b1, 1'b0, 32'h0);
    clear_req();

    // misaligned flush: pulse, capture, hold, HALT
    bus.flush_pc = 1'b1; bus.new_pc = 32'h202;
    tick(); expect_state("mis_flush", 32'h800, 1'b0, 1'b1, 32'h202);
    clear_req();
    tick(); expect_state("halt_hold", 32'h800, 1'b0, 1'b0, 32'h202);
    bus.flush_pc = 1'b1; bus.new_pc = 32'h300;
    tick(); expect_state("halt_noflush", 32'h800, 1'b0, 1'b0, 32'h202);
    clear_req();
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h400;
    tick(); expect_state("trap_exit", 32'h400, 1'b1, 1'b0, 32'h202);
    clear_req();

    // misaligned taken branch
    bus.br_inst = 1'b1; bus.br_cond = 1'b1; bus.br_offset = 32'h2;
    tick(); expect_state("mis_branch", 32'h400, 1'b0, 1'b1, 32'h402);
    clear_req();

    // wrap at top of address space
    bus.trap_valid = 1'b1; bus.trap_pc = 32'hFFFF_FFFC;
    tick(); check("top", bus.pc, 32'hFFFF_FFFC);
    clear_req();
    tick(); expect_state("wrap", 32'h0, 1'b1, 1'b0, 32'h402);

    // enter HALT, then reset overrides it
    bus.flush_pc = 1'b1; bus.new_pc = 32'h1;
    tick(); expect_state("halt2", 32'h0, 1'b0, 1'b1, 32'h1);
    rst = 1'b1;
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h500;
    tick(); expect_state("rst_halt", 32'h0, 1'b0, 1'b0, 32'h0);
    clear_req();
    rst = 1'b0;
    tick(); expect_state("rst_run", 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); check("rst_seq", bus.pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_gen
